// File: rtl/hilo_muldiv.sv
// hilo_muldiv: 32-bit signed Booth multiply / restoring divide into HI/LO (clock, reset, start, op, a_in, b_in -> hi_out, lo_out, busy, done, div_by_zero)
module hilo_muldiv (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);
  localparam logic [1:0] IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, FINISH = 2'd3;
  logic [1:0] state;
  logic [5:0] cnt;
  logic [31:0] a_r, b_r, acc, q, abs_a, abs_b, m_acc, m_q, d_acc, d_q, q_fix, r_fix;
  logic [32:0] bsum, dsub;
  logic q1, dz;
  always_comb begin
    abs_a = a_r[31] ? -a_r : a_r;
    abs_b = b_r[31] ? -b_r : b_r;
    bsum = {q[0], q1} == 2'b01 ? {acc[31], acc} + {b_r[31], b_r} :
           {q[0], q1} == 2'b10 ? {acc[31], acc} - {b_r[31], b_r} : {acc[31], acc};
    m_acc = bsum[32:1];
    m_q = {bsum[0], q[31:1]};
    dsub = {acc, q[31]} - {1'b0, abs_b};
    d_acc = dsub[32] ? {acc[30:0], q[31]} : dsub[31:0];
    d_q = {q[30:0], ~dsub[32]};
    q_fix = (a_r[31] ^ b_r[31]) ? -d_q : d_q;
    r_fix = a_r[31] ? -d_acc : d_acc;
  end
  assign busy = state == MULT || state == DIV;
  assign done = state == FINISH;
  assign div_by_zero = done && dz;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      q <= '0;
      q1 <= 1'b0;
      dz <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r <= a_in;
          b_r <= b_in;
          cnt <= '0;
          state <= op ? DIV : MULT;
        end
        MULT: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'd0) begin
            acc <= '0;
            q <= a_r;
            q1 <= 1'b0;
          end else begin
            acc <= m_acc;
            q <= m_q;
            q1 <= q[0];
          end
          if (cnt == 6'd32) begin
            state <= FINISH;
            hi_out <= m_acc;
            lo_out <= m_q;
            dz <= 1'b0;
          end
        end
        DIV: begin
          cnt <= cnt + 6'd1;
          if (b_r == '0) begin
            state <= FINISH;
            dz <= 1'b1;
          end else if (cnt == 6'd0) begin
            acc <= '0;
            q <= abs_a;
          end else begin
            acc <= d_acc;
            q <= d_q;
            if (cnt == 6'd32) begin
              state <= FINISH;
              hi_out <= r_fix;
              lo_out <= q_fix;
              dz <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed and scoreboard-checked stimulus for hilo_muldiv
module tb_hilo_muldiv;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0;
  logic [31:0] a_in = '0, b_in = '0, hi_out, lo_out;
  logic busy, done, div_by_zero;
  typedef struct {logic [31:0] hi; logic [31:0] lo; logic dz; int lat;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  logic [31:0] prev_hi = '0, prev_lo = '0;
  hilo_muldiv dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b, input bit inj);
    exp_t e;
    exp_t g;
    longint x, y, r;
    bit seen = 0;
    int cyc = 1;
    x = longint'($signed(a));
    y = longint'($signed(b));
    if (!o) begin
      r = x * y;
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.dz = 0;
      e.lat = 34;
    end else if (b == 0) begin
      e.hi = prev_hi;
      e.lo = prev_lo;
      e.dz = 1;
      e.lat = 2;
    end else begin
      r = x / y;
      e.lo = r[31:0];
      r = x % y;
      e.hi = r[31:0];
      e.dz = 0;
      e.lat = 34;
    end
    prev_hi = e.hi;
    prev_lo = e.lo;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b1;
    op = o;
    a_in = a;
    b_in = b;
    @(negedge clock);
    start = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    while (!seen && cyc <= 40) begin
      start = inj && cyc == 5;
      op = ~o;
      chk("busy", busy, cyc < e.lat);
      if (done) begin
        seen = 1;
        if (sb.size() == 0) chk("queue_empty", 1, 0);
        else begin
          g = sb.pop_front();
          chk("hi_out", hi_out, g.hi);
          chk("lo_out", lo_out, g.lo);
          chk("div_by_zero", div_by_zero, g.dz);
          chk("latency", cyc, g.lat);
        end
      end else chk("dz_without_done", div_by_zero, 0);
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    for (int i = 0; i < (inj ? 40 : 2); i++) begin
      chk("extra_done", done, 0);
      @(negedge clock);
    end
  endtask
  initial begin
    repeat (3) @(negedge clock);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    reset = 1'b0;
    run(0, 32'd7, 32'hFFFFFFFD, 0);
    run(0, 32'h80000000, 32'h80000000, 0);
    run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run(1, 32'hFFFFFFF9, 32'd2, 0);
    run(1, 32'h80000000, 32'hFFFFFFFF, 0);
    run(1, 32'd5, 32'd0, 0);
    run(1, 32'd7, 32'hFFFFFFFE, 0);
    run(1, 32'd3, 32'd10, 0);
    for (int i = 0; i < 3; i++) run(0, $urandom, $urandom, 0);
    for (int i = 0; i < 3; i++) run(1, $urandom, $urandom_range(1, 1000), 0);
    run(0, 32'h12345678, 32'hFEDCBA98, 1);
    @(negedge clock);
    start = 1'b1;
    op = 1'b0;
    a_in = 32'd3;
    b_in = 32'd4;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("abort_hi", hi_out, 0);
    chk("abort_lo", lo_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dz", div_by_zero, 0);
    reset = 1'b0;
    prev_hi = '0;
    prev_lo = '0;
    for (int i = 0; i < 40; i++) begin
      chk("abort_no_done", done, 0);
      @(negedge clock);
    end
    run(0, 32'd3, 32'd4, 0);
    chk("queue_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 Parameters: none; the block is fixed at 32-bit operands.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  1  0 = signed multiply (MULT), 1 = signed divide (DIV); sampled with start.
REQ-006 a_in  input  32  operand A (register-file port A value); sampled with start.
REQ-007 b_in  input  32  operand B (register-file port B value); sampled with start.
REQ-008 hi_out  output  32  result high word: MULT product[63:32], DIV remainder; feeds the HI register.
REQ-009 lo_out  output  32  result low word: MULT product[31:0], DIV quotient; feeds the LO register.
REQ-010 busy  output  1  high while an operation is in progress (MULT or DIV state).
REQ-011 done  output  1  single-cycle pulse; hi_out/lo_out are valid in this cycle; used by control to write HI/LO.
REQ-012 div_by_zero  output  1  single-cycle pulse, coincident with done, when DIV has b_in == 0.

Function
REQ-013 The FSM SHALL have states IDLE, MULT, DIV, FINISH.
REQ-014 In IDLE, start=1 SHALL latch a_in, b_in and op, clear the iteration counter, and go to MULT (op=0) or DIV (op=1) on the next edge.
REQ-015 start SHALL be ignored in every state except IDLE; operand changes after the latching edge SHALL have no effect.
REQ-016 MULT SHALL use radix-2 Booth:
- 65-bit {acc[31:0], q[31:0], q_-1}, with acc=0 and q=A at entry.
- Each cycle, examine {q[0], q_-1}: 01 -> acc += M, 10 -> acc -= M (mod 2^32), 00/11 -> no change.
- Then arithmetic-shift the whole 65-bit value right by 1.
REQ-017 MULT SHALL perform exactly 32 iterations, one per cycle, then enter FINISH.
REQ-018 DIV with latched B == 0 SHALL skip iteration and enter FINISH immediately.
- In FINISH, assert div_by_zero=1 with done=1.
- hi_out/lo_out SHALL keep their previous values.
REQ-019 DIV with B != 0 SHALL perform 32-iteration restoring division on |A| and |B|, one quotient bit per cycle, then enter FINISH.
REQ-020 Signed DIV results SHALL truncate toward zero:
- quotient negated iff sign(A) XOR sign(B) = 1;
- remainder takes the sign of A;
- |remainder| < |B|.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo_out=0x80000000 and hi_out=0x00000000 (wrap); no flag is raised.
REQ-022 FINISH SHALL last exactly one cycle:
- done=1 and hi_out/lo_out updated from internal state on entry;
- then return to IDLE.
REQ-023 Latency from the cycle start is sampled to the done cycle:
- MULT and nonzero DIV: 34 cycles (start at cycle 0, done at cycle 34);
- DIV by zero: 2 cycles.
REQ-024 hi_out/lo_out SHALL hold their last result until the next FINISH.
- They are registered, glitch-free, and unchanged during MULT/DIV iterations.
REQ-025 busy SHALL be 1 exactly in MULT and DIV states, and 0 in IDLE and FINISH.
REQ-026 done and div_by_zero SHALL never be high outside FINISH.

Reset
REQ-027 reset=1 at a clock edge SHALL force state IDLE, hi_out=0, lo_out=0, busy=0, done=0, div_by_zero=0, and clear counter and internal operand registers.
REQ-028 reset SHALL override start in the same cycle.
REQ-029 A reset during MULT/DIV SHALL abort the operation with no done pulse and no partial result visible.

Verification
REQ-030 MULT A=7, B=0xFFFFFFFD (-3), start at cycle 0 -> done at cycle 34 with hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy high cycles 1-33.
REQ-031 MULT A=B=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000; second case 0xFFFFFFFF*0xFFFFFFFF -> hi_out=0, lo_out=1.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF, div_by_zero=0; DIV 0x80000000/0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
REQ-033 DIV A=5, B=0 after a prior result -> done and div_by_zero high at cycle 2; hi_out/lo_out unchanged from the prior result.
REQ-034 MULT 3*4 started, reset=1 at cycle 10 -> all outputs 0 the following cycle and no done pulse.
- Then start MULT 3*4 -> lo_out=12, hi_out=0 at done.
REQ-035 start pulsed with new operands at cycle 5 of a running MULT -> ignored; the original result is produced at cycle 34 and no second done appears.
